// File: rtl/y86_pkg.sv
// Shared Y86 definitions: icode constants, per-icode instruction length and
// the encoder FSM state type. Fetch is to use the same constants.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  // Encoded length in bytes; 0 marks an invalid icode.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      I_HALT, I_NOP, I_RET:               instr_len = 4'd1;
      I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ:   instr_len = 4'd2;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:       instr_len = 4'd10;
      I_JXX, I_CALL:                      instr_len = 4'd9;
      default:                            instr_len = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational icode -> instruction length decoder, shared with fetch (valP).
// Ports:
//   icode  in  4  instruction code
//   len    out 4  length in bytes (0 when invalid)
//   valid  out 1  icode is a defined instruction
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       valid
);

  assign len   = instr_len(icode);
  assign valid = (len != 4'd0);

endmodule

// File: rtl/y86_instr_encoder.sv
// Y86 instruction encoder: takes decoded fields and writes the instruction
// into byte-wide instruction memory one byte per cycle, in the layout fetch
// decodes. A write pointer lays successive instructions out contiguously.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid / in_ready      instruction handshake
//   icode, ifun, rA, rB, valC decoded instruction fields
//   ptr_load, ptr_val        reload the write pointer (IDLE only)
//   mem_we, mem_addr, mem_wdata  byte write port
//   wr_ptr                   next free byte address
//   instr_done               pulse after the last byte of an instruction
//   enc_err                  pulse on invalid icode or memory overflow
module y86_instr_encoder
  import y86_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  input  logic              ptr_load,
  input  logic [ADDR_W-1:0] ptr_val,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              instr_done,
  output logic              enc_err
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);

  state_t          state;
  logic [3:0]      idx;
  logic [3:0]      len_q;
  logic [9:0][7:0] sbuf;

  logic [3:0]      len_c;
  logic            len_ok;
  logic [9:0][7:0] bytes_c;
  logic [ADDR_W:0] end_x;
  logic            fits;

  y86_instr_len u_len (
    .icode (icode),
    .len   (len_c),
    .valid (len_ok)
  );

  assign in_ready = (state == IDLE) && !ptr_load;

  // One extra bit so wr_ptr+len == MEM_DEPTH (exact fit) is distinguishable
  // from an overflow.
  assign end_x = {1'b0, wr_ptr} + {{(ADDR_W-3){1'b0}}, len_c};
  assign fits  = (end_x <= DEPTH_X);

  // Byte image in memory order; valC goes big-endian (MSB at lowest address).
  always_comb begin
    bytes_c    = '0;
    bytes_c[0] = {icode, ifun};
    case (len_c)
      4'd2:  bytes_c[1] = {rA, rB};
      4'd10: begin
        bytes_c[1] = {rA, rB};
        for (int i = 0; i < 8; i++) bytes_c[2+i] = valC[63-8*i -: 8];
      end
      4'd9:  for (int i = 0; i < 8; i++) bytes_c[1+i] = valC[63-8*i -: 8];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      len_q      <= '0;
      sbuf       <= '0;
      wr_ptr     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      instr_done <= 1'b0;
      enc_err    <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      instr_done <= 1'b0;
      enc_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (ptr_load) begin
            wr_ptr <= ptr_val;
          end else if (in_valid) begin
            if (!len_ok || !fits) begin
              enc_err <= 1'b1;
            end else begin
              // Byte 0 is issued on the acceptance edge so it is on the bus
              // the cycle after acceptance; the buffer keeps bytes 1..9.
              mem_we    <= 1'b1;
              mem_addr  <= wr_ptr;
              mem_wdata <= bytes_c[0];
              sbuf      <= {8'h00, bytes_c[9:1]};
              len_q     <= len_c;
              idx       <= 4'd1;
              state     <= EMIT;
            end
          end
        end
        EMIT: begin
          if (idx == len_q) begin
            // Last byte is on the bus this cycle; commit the pointer.
            instr_done <= 1'b1;
            wr_ptr     <= wr_ptr + ADDR_W'(len_q);
            state      <= IDLE;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= wr_ptr + ADDR_W'(idx);
            mem_wdata <= sbuf[0];
            sbuf      <= {8'h00, sbuf[9:1]};
            idx       <= idx + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_instr_encoder.sv
module tb_y86_instr_encoder;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [3:0]    icode, ifun, rA, rB;
  logic [63:0]   valC;
  logic          ptr_load;
  logic [AW-1:0] ptr_val;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [AW-1:0] wr_ptr;
  logic          instr_done, enc_err;

  y86_instr_encoder #(.ADDR_W(AW), .MEM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .ptr_load(ptr_load), .ptr_val(ptr_val),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .wr_ptr(wr_ptr), .instr_done(instr_done), .enc_err(enc_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  wr_t sbq[$];
  wr_t mon_e;

  int vectors = 0, miscompares = 0;
  int done_cnt = 0, err_cnt = 0;
  int model_ptr = 0;
  time acc_t;

  // Scoreboard: every write strobe is matched against the next expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (instr_done) done_cnt++;
      if (enc_err) err_cnt++;
      if (mem_we) begin
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write addr=%0d data=%h", mem_addr, mem_wdata);
        end else begin
          mon_e = sbq.pop_front();
          if (mem_addr !== mon_e.a || mem_wdata !== mon_e.d) begin
            miscompares++;
            $display("FAIL mem_write got addr=%0d data=%h want addr=%0d data=%h",
                     mem_addr, mem_wdata, mon_e.a, mon_e.d);
          end
        end
      end
    end
  end

  function automatic int tb_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h3, 4'h4, 4'h5:       return 10;
      4'h7, 4'h8:             return 9;
      default:                return 0;
    endcase
  endfunction

  task automatic send(input logic [3:0] ic, input logic [3:0] ifn,
                      input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc);
    int n, pos, guard;
    logic [7:0] b [10];
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_ready_timeout in_ready=%b want 1", in_ready);
      return;
    end
    icode = ic; ifun = ifn; rA = ra; rB = rb; valC = vc; in_valid = 1'b1;
    n = tb_len(ic);
    if (n != 0 && model_ptr + n <= 1024) begin
      b[0] = {ic, ifn};
      pos = 1;
      if (n == 2 || n == 10) begin b[pos] = {ra, rb}; pos++; end
      if (n >= 9) for (int k = 0; k < 8; k++) begin b[pos] = 8'(vc >> (56 - 8*k)); pos++; end
      for (int k = 0; k < n; k++) sbq.push_back('{a: AW'(model_ptr + k), d: b[k]});
      model_ptr = (model_ptr + n) % 1024;
    end
    @(posedge clk);
    acc_t = $time;
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    @(negedge clk);
    while (!(sbq.size() == 0 && in_ready) && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout pending=%0d want 0", sbq.size());
    end
    @(negedge clk);
  endtask

  task automatic ptr_set(input int v);
    @(negedge clk);
    ptr_load = 1'b1; ptr_val = AW'(v);
    @(posedge clk);
    #1 ptr_load = 1'b0;
    model_ptr = v;
    vectors++;
    if (wr_ptr !== AW'(v)) begin
      miscompares++;
      $display("FAIL ptr_load wr_ptr=%0d want %0d", wr_ptr, v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; icode = 0; ifun = 0; rA = 0; rB = 0; valC = 0;
    ptr_load = 0; ptr_val = 0;
    repeat (3) @(posedge clk);
    #1 vectors++;
    if ({mem_we, mem_addr, mem_wdata, wr_ptr, instr_done, enc_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs we=%b addr=%0d data=%h ptr=%0d done=%b err=%b want all 0",
               mem_we, mem_addr, mem_wdata, wr_ptr, instr_done, enc_err);
    end
    @(negedge clk) rst = 1'b0;
    #1 vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_irmovq();
    int d0 = done_cnt;
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF);
    wait_drain();
    vectors++;
    if (wr_ptr !== 10) begin miscompares++; $display("FAIL irmovq_ptr got %0d want 10", wr_ptr); end
    vectors++;
    if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL irmovq_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int d0;
    time t1;
    ptr_set(0);
    d0 = done_cnt;
    send(4'h6, 4'h0, 4'h4, 4'h2, 64'h0);
    t1 = acc_t;
    send(4'h0, 4'h0, 4'hF, 4'hF, 64'h0);
    vectors++;
    if (acc_t - t1 != 30) begin miscompares++; $display("FAIL b2b_throughput got %0t want 30", acc_t - t1); end
    wait_drain();
    vectors++;
    if (wr_ptr !== 3) begin miscompares++; $display("FAIL b2b_ptr got %0d want 3", wr_ptr); end
    vectors++;
    if (done_cnt - d0 != 2) begin miscompares++; $display("FAIL b2b_done got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_call();
    int d0 = done_cnt;
    send(4'h8, 4'h0, 4'hF, 4'hF, 64'h100);
    wait_drain();
    vectors++;
    if (wr_ptr !== 12) begin miscompares++; $display("FAIL call_ptr got %0d want 12", wr_ptr); end
    vectors++;
    if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL call_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_invalid();
    int e0 = err_cnt, d0 = done_cnt;
    send(4'hC, 4'h0, 4'h1, 4'h2, 64'hFFFF);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL invalid_ready got %b want 1", in_ready); end
    wait_drain();
    vectors++;
    if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL invalid_err got %0d want 1", err_cnt - e0); end
    vectors++;
    if (wr_ptr !== 12 || done_cnt != d0) begin
      miscompares++; $display("FAIL invalid_ptr got ptr=%0d done=%0d want ptr=12 done=0", wr_ptr, done_cnt - d0);
    end
  endtask

  task automatic test_overflow();
    int e0, d0;
    ptr_set(1020);
    e0 = err_cnt;
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h55);
    wait_drain();
    vectors++;
    if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL ovf_err got %0d want 1", err_cnt - e0); end
    vectors++;
    if (wr_ptr !== 1020) begin miscompares++; $display("FAIL ovf_ptr got %0d want 1020", wr_ptr); end
    ptr_set(1022);
    e0 = err_cnt; d0 = done_cnt;
    send(4'hB, 4'h0, 4'h3, 4'hF, 64'h0);
    wait_drain();
    vectors++;
    if (wr_ptr !== 0) begin miscompares++; $display("FAIL fit_ptr got %0d want 0", wr_ptr); end
    vectors++;
    if (err_cnt != e0 || done_cnt - d0 != 1) begin
      miscompares++; $display("FAIL fit_flags got err=%0d done=%0d want err=0 done=1", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_ptr_priority();
    int d0 = done_cnt;
    @(negedge clk);
    ptr_load = 1'b1; ptr_val = AW'(200);
    icode = 4'h1; ifun = 4'h0; in_valid = 1'b1;
    #1 vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL prio_ready got %b want 0", in_ready); end
    @(posedge clk);
    #1 ptr_load = 1'b0; in_valid = 1'b0;
    model_ptr = 200;
    wait_drain();
    vectors++;
    if (wr_ptr !== 200 || done_cnt != d0) begin
      miscompares++; $display("FAIL prio_ptr got ptr=%0d done=%0d want ptr=200 done=0", wr_ptr, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_emit();
    ptr_set(100);
    @(negedge clk);
    icode = 4'h3; ifun = 4'h0; rA = 4'hF; rB = 4'h2; valC = 64'h0123456789ABCDEF; in_valid = 1'b1;
    sbq.push_back('{a: AW'(100), d: 8'h30});
    sbq.push_back('{a: AW'(101), d: 8'hF2});
    sbq.push_back('{a: AW'(102), d: 8'h01});
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 vectors++;
    if (mem_we !== 1'b0 || wr_ptr !== 0) begin
      miscompares++; $display("FAIL midrst_async got we=%b ptr=%0d want we=0 ptr=0", mem_we, wr_ptr);
    end
    @(negedge clk) rst = 1'b0;
    model_ptr = 0;
    vectors++;
    if (sbq.size() != 0) begin miscompares++; $display("FAIL midrst_bytes pending=%0d want 0", sbq.size()); end
    send(4'h1, 4'h0, 4'hF, 4'hF, 64'h0);
    wait_drain();
    vectors++;
    if (wr_ptr !== 1) begin miscompares++; $display("FAIL midrst_next_ptr got %0d want 1", wr_ptr); end
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_back_to_back();
    test_call();
    test_invalid();
    test_overflow();
    test_ptr_priority();
    test_reset_mid_emit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
